// File: rtl/bus_a8_pkg.sv
// Shared definitions for the A8 aperture mapper: register byte offsets,
// per-aperture register file type, map-rebuild state encoding, and the
// default host page that holds the aperture registers.
package bus_a8_pkg;

   localparam logic [7:0] PAGE_MEM_AP_DEFAULT = 8'hD6;

   // Byte offsets inside one 16-byte aperture block
   localparam logic [3:0] AP_OFS_BASE0  = 4'h0;
   localparam logic [3:0] AP_OFS_BASE1  = 4'h1;
   localparam logic [3:0] AP_OFS_BASE2  = 4'h2;
   localparam logic [3:0] AP_OFS_BASE3  = 4'h3;
   localparam logic [3:0] AP_OFS_START  = 4'h4;
   localparam logic [3:0] AP_OFS_COUNT  = 4'h5;
   localparam logic [3:0] AP_OFS_STRIDE = 4'h6;
   localparam logic [3:0] AP_OFS_X_LO   = 4'h7;
   localparam logic [3:0] AP_OFS_X_HI   = 4'h8;
   localparam logic [3:0] AP_OFS_Y_LO   = 4'h9;
   localparam logic [3:0] AP_OFS_Y_HI   = 4'hA;
   localparam logic [3:0] AP_OFS_W_LO   = 4'hB;
   localparam logic [3:0] AP_OFS_W_HI   = 4'hC;
   localparam logic [3:0] AP_OFS_H_LO   = 4'hD;
   localparam logic [3:0] AP_OFS_H_HI   = 4'hE;
   localparam logic [3:0] AP_OFS_RSVD   = 4'hF;

   typedef logic [15:0][7:0] ap_regs_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SWEEP  = 2'd1,
      ST_COMMIT = 2'd2
   } map_state_e;

   // Last page covered by an aperture, clipped at $FF instead of wrapping
   function automatic logic [7:0] ap_last_page(input logic [7:0] start, input logic [7:0] count);
      logic [8:0] sum;
      sum = {1'b0, start} + {1'b0, count} - 9'd1;
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/bus_a8_aperture.sv
// One aperture: 16 byte registers plus decoded enable / first / last page.
// With BUS_A8_READBACK_EN defined the raw bytes are exported for readback.
import bus_a8_pkg::*;

module bus_a8_aperture (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [3:0]       ofs,
   input  logic [7:0]       wdata,
`ifdef BUS_A8_READBACK_EN
   output logic [15:0][7:0] regs,
`endif
   output logic             enable,
   output logic [7:0]       start_page,
   output logic [7:0]       end_page
);

   ap_regs_t regs_q, regs_d;

   // Byte write into the register file
   always_comb begin
      regs_d = regs_q;
      if (we) regs_d[ofs] = wdata;
   end

   // Register file storage
   always_ff @(posedge clk) begin
      if (rst) regs_q <= '0;
      else     regs_q <= regs_d;
   end

`ifdef BUS_A8_READBACK_EN
   assign regs = regs_q;
`endif
   assign enable     = (regs_q[AP_OFS_COUNT] != 8'h00);
   assign start_page = regs_q[AP_OFS_START];
   assign end_page   = ap_last_page(regs_q[AP_OFS_START], regs_q[AP_OFS_COUNT]);

endmodule

// File: rtl/bus_a8_apmap.sv
// A8 bus aperture mapper: tracks A8 phi2 in the 200 MHz domain, decodes
// page hits against a committed 256-bit page map, captures aperture
// register writes and rebuilds the map in 16 chunks before committing.
// Optional register readback: define BUS_A8_READBACK_EN.
import bus_a8_pkg::*;

module bus_a8_apmap #(
   parameter int         TICK_BITS          = 7,
   parameter int         TICK_ADDRESS_VALID = 33,
   parameter int         TICK_WRITE_VALID   = 82,
   parameter int         TICK_READ_VALID    = 70,
   parameter int         NUM_AP             = 4,
   parameter logic [7:0] PAGE_MEM_AP        = PAGE_MEM_AP_DEFAULT
) (
   input  logic        clk200,
   input  logic        rst,
   input  logic        a8_clk,
   input  logic        a8_rw_n,
   input  logic        a8_rst_n,
   input  logic [15:0] a8_addr,
   input  logic [7:0]  a8_data,
   output logic        a8_extsel_n,
   output logic        a8_mpd_n,
   output logic        ap_hit,
   output logic [3:0]  ap_idx,
   output logic [7:0]  ap_page_ofs,
   output logic        reg_wr,
   output logic [3:0]  reg_ap,
   output logic [3:0]  reg_ofs,
   output logic [7:0]  reg_data,
   output logic [7:0]  a8_data_out,
   output logic        a8_data_oe
);

   localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] S_SWEEP  = 2'(ST_SWEEP);
   localparam logic [1:0] S_COMMIT = 2'(ST_COMMIT);

   logic [2:0]           sync_q, sync_d;
   logic [TICK_BITS-1:0] tick_q, tick_d;
   logic [15:0]          addr_q, addr_d;
   logic                 extsel_q, extsel_d, mpd_q, mpd_d, hit_q, hit_d;
   logic [3:0]           idx_q, idx_d;
   logic [7:0]           pofs_q, pofs_d;
   logic                 reg_wr_q, reg_wr_d;
   logic [3:0]           reg_ap_q, reg_ap_d, reg_ofs_q, reg_ofs_d;
   logic [7:0]           reg_data_q, reg_data_d;
   logic [1:0]           state_q, state_d;
   logic [3:0]           chunk_q, chunk_d;
   logic                 pend_q, pend_d;
   logic [255:0]         shadow_q, shadow_d, live_q, live_d;

   logic                 fall, addr_tick, sel_ok, wr_fire, trigger, lk_found;
   logic [3:0]           lk_idx;
   logic [7:0]           lk_ofs, page_now;
   logic [15:0]          chunk_bits;
   logic [NUM_AP-1:0]    ap_en;
   logic [7:0]           ap_start [NUM_AP];
   logic [7:0]           ap_end   [NUM_AP];

   assign fall      = sync_q[2] & ~sync_q[1];
   assign addr_tick = (tick_q == TICK_BITS'(TICK_ADDRESS_VALID));
   assign page_now  = a8_addr[15:8];
   assign sel_ok    = (addr_q[15:8] == PAGE_MEM_AP) && ({28'd0, addr_q[7:4]} < 32'(NUM_AP));
   assign wr_fire   = a8_rst_n && !fall && !a8_rw_n && sel_ok
                      && (tick_q == TICK_BITS'(TICK_WRITE_VALID));
   assign trigger   = wr_fire && ((addr_q[3:0] == AP_OFS_START) || (addr_q[3:0] == AP_OFS_COUNT));

`ifdef BUS_A8_READBACK_EN
   logic [15:0][7:0] ap_regs [NUM_AP];
`endif

   for (genvar g = 0; g < NUM_AP; g++) begin : g_ap
      bus_a8_aperture u_ap (
         .clk        (clk200),
         .rst        (rst),
         .we         (wr_fire && (addr_q[7:4] == 4'(g))),
         .ofs        (addr_q[3:0]),
         .wdata      (a8_data),
`ifdef BUS_A8_READBACK_EN
         .regs       (ap_regs[g]),
`endif
         .enable     (ap_en[g]),
         .start_page (ap_start[g]),
         .end_page   (ap_end[g])
      );
   end

   // Lowest-index aperture containing the current page supplies index/offset
   always_comb begin
      lk_found = 1'b0;
      lk_idx   = '0;
      lk_ofs   = '0;
      for (int unsigned i = 0; i < NUM_AP; i++) begin
         if (!lk_found && ap_en[i] && page_now >= ap_start[i] && page_now <= ap_end[i]) begin
            lk_found = 1'b1;
            lk_idx   = 4'(i);
            lk_ofs   = page_now - ap_start[i];
         end
      end
   end

   // Map bits for the 16 pages of the chunk currently being swept
   always_comb begin
      chunk_bits = '0;
      for (int unsigned j = 0; j < 16; j++) begin
         for (int unsigned i = 0; i < NUM_AP; i++) begin
            if (ap_en[i] && {chunk_q, 4'(j)} >= ap_start[i] && {chunk_q, 4'(j)} <= ap_end[i])
               chunk_bits[j] = 1'b1;
         end
      end
   end

   // Phi2 tracking, tick counter, address-phase decode and write strobe
   always_comb begin
      sync_d     = {sync_q[1:0], a8_clk};
      tick_d     = (tick_q == '1) ? tick_q : tick_q + 1'b1;
      addr_d     = addr_q;
      extsel_d   = extsel_q;
      mpd_d      = mpd_q;
      hit_d      = hit_q;
      idx_d      = idx_q;
      pofs_d     = pofs_q;
      if (fall) begin
         tick_d   = '0;
         extsel_d = 1'b1;
         mpd_d    = 1'b1;
         hit_d    = 1'b0;
      end else if (addr_tick) begin
         addr_d   = a8_addr;
         extsel_d = ~live_q[page_now];
         hit_d    = live_q[page_now];
         mpd_d    = ~(live_q[page_now] && (page_now[7:3] == 5'b11011));
         idx_d    = lk_idx;
         pofs_d   = lk_ofs;
      end
      if (!a8_rst_n) begin
         sync_d   = '0;
         tick_d   = '0;
         extsel_d = 1'b1;
         mpd_d    = 1'b1;
         hit_d    = 1'b0;
         idx_d    = '0;
         pofs_d   = '0;
      end
      reg_wr_d   = wr_fire;
      reg_ap_d   = wr_fire ? addr_q[7:4] : reg_ap_q;
      reg_ofs_d  = wr_fire ? addr_q[3:0] : reg_ofs_q;
      reg_data_d = wr_fire ? a8_data     : reg_data_q;
   end

   // Map rebuild: sweep 16 chunks into shadow, then commit to live.
   // A start/count write during a sweep makes COMMIT skip the copy and
   // re-sweep, so live_map only ever moves to a map built from final values.
   always_comb begin
      state_d  = state_q;
      chunk_d  = chunk_q;
      pend_d   = pend_q;
      shadow_d = shadow_q;
      live_d   = live_q;
      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d = S_SWEEP;
               chunk_d = '0;
            end
         end
         S_SWEEP: begin
            shadow_d[{chunk_q, 4'b0000} +: 16] = chunk_bits;
            if (trigger) pend_d = 1'b1;
            if (chunk_q == 4'hF) state_d = S_COMMIT;
            else                 chunk_d = chunk_q + 4'd1;
         end
         S_COMMIT: begin
            if (pend_q || trigger) begin
               state_d = S_SWEEP;
               chunk_d = '0;
               pend_d  = 1'b0;
            end else begin
               live_d  = shadow_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers
   always_ff @(posedge clk200) begin
      if (rst) begin
         sync_q     <= '0;
         tick_q     <= '0;
         addr_q     <= '0;
         extsel_q   <= 1'b1;
         mpd_q      <= 1'b1;
         hit_q      <= 1'b0;
         idx_q      <= '0;
         pofs_q     <= '0;
         reg_wr_q   <= 1'b0;
         reg_ap_q   <= '0;
         reg_ofs_q  <= '0;
         reg_data_q <= '0;
         state_q    <= S_IDLE;
         chunk_q    <= '0;
         pend_q     <= 1'b0;
         shadow_q   <= '0;
         live_q     <= '0;
      end else begin
         sync_q     <= sync_d;
         tick_q     <= tick_d;
         addr_q     <= addr_d;
         extsel_q   <= extsel_d;
         mpd_q      <= mpd_d;
         hit_q      <= hit_d;
         idx_q      <= idx_d;
         pofs_q     <= pofs_d;
         reg_wr_q   <= reg_wr_d;
         reg_ap_q   <= reg_ap_d;
         reg_ofs_q  <= reg_ofs_d;
         reg_data_q <= reg_data_d;
         state_q    <= state_d;
         chunk_q    <= chunk_d;
         pend_q     <= pend_d;
         shadow_q   <= shadow_d;
         live_q     <= live_d;
      end
   end

   assign a8_extsel_n = extsel_q;
   assign a8_mpd_n    = mpd_q;
   assign ap_hit      = hit_q;
   assign ap_idx      = idx_q;
   assign ap_page_ofs = pofs_q;
   assign reg_wr      = reg_wr_q;
   assign reg_ap      = reg_ap_q;
   assign reg_ofs     = reg_ofs_q;
   assign reg_data    = reg_data_q;

`ifdef BUS_A8_READBACK_EN
   logic       rb_oe_q, rb_oe_d;
   logic [7:0] rb_data_q, rb_data_d;

   // Drive aperture register contents from the read tick until the next phi2 fall
   always_comb begin
      rb_oe_d   = rb_oe_q;
      rb_data_d = rb_data_q;
      if (fall) begin
         rb_oe_d   = 1'b0;
         rb_data_d = '0;
      end else if (a8_rw_n && sel_ok && (tick_q == TICK_BITS'(TICK_READ_VALID))) begin
         rb_oe_d = 1'b1;
         for (int unsigned i = 0; i < NUM_AP; i++) begin
            if (addr_q[7:4] == 4'(i)) rb_data_d = ap_regs[i][addr_q[3:0]];
         end
      end
      if (!a8_rst_n) begin
         rb_oe_d   = 1'b0;
         rb_data_d = '0;
      end
   end

   // Readback registers
   always_ff @(posedge clk200) begin
      if (rst) begin
         rb_oe_q   <= 1'b0;
         rb_data_q <= '0;
      end else begin
         rb_oe_q   <= rb_oe_d;
         rb_data_q <= rb_data_d;
      end
   end

   assign a8_data_out = rb_data_q;
   assign a8_data_oe  = rb_oe_q;
`else
   assign a8_data_out = '0;
   assign a8_data_oe  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_a8_apmap.sv
// Directed bench for bus_a8_apmap: vector table of A8 bus cycles plus
// hand sequences for reset, A8 /RST, rebuild restart and reset mid-sweep.
module tb_bus_a8_apmap;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a8_clk = 1'b1, a8_rw_n = 1'b1, a8_rst_n = 1'b1;
   logic [15:0] a8_addr = '0;
   logic [7:0]  a8_data = '0;
   logic        a8_extsel_n, a8_mpd_n, ap_hit, reg_wr, a8_data_oe;
   logic [3:0]  ap_idx, reg_ap, reg_ofs;
   logic [7:0]  ap_page_ofs, reg_data, a8_data_out;

   logic        f_clk = 1'b1, f_rw_n = 1'b1;
   logic [15:0] f_addr = '0;
   logic [7:0]  f_data = '0;
   logic        f_extsel_n, f_mpd_n, f_hit, f_reg_wr, f_oe;
   logic [3:0]  f_idx, f_reg_ap, f_reg_ofs;
   logic [7:0]  f_pofs, f_reg_data, f_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_a8_apmap dut (
      .clk200(clk), .rst(rst), .a8_clk(a8_clk), .a8_rw_n(a8_rw_n), .a8_rst_n(a8_rst_n),
      .a8_addr(a8_addr), .a8_data(a8_data), .a8_extsel_n(a8_extsel_n), .a8_mpd_n(a8_mpd_n),
      .ap_hit(ap_hit), .ap_idx(ap_idx), .ap_page_ofs(ap_page_ofs), .reg_wr(reg_wr),
      .reg_ap(reg_ap), .reg_ofs(reg_ofs), .reg_data(reg_data),
      .a8_data_out(a8_data_out), .a8_data_oe(a8_data_oe)
   );

   // Short-tick instance: lets register writes land while a sweep is running
   bus_a8_apmap #(.TICK_ADDRESS_VALID(2), .TICK_WRITE_VALID(4), .TICK_READ_VALID(3)) dut_fast (
      .clk200(clk), .rst(rst), .a8_clk(f_clk), .a8_rw_n(f_rw_n), .a8_rst_n(1'b1),
      .a8_addr(f_addr), .a8_data(f_data), .a8_extsel_n(f_extsel_n), .a8_mpd_n(f_mpd_n),
      .ap_hit(f_hit), .ap_idx(f_idx), .ap_page_ofs(f_pofs), .reg_wr(f_reg_wr),
      .reg_ap(f_reg_ap), .reg_ofs(f_reg_ofs), .reg_data(f_reg_data),
      .a8_data_out(f_dout), .a8_data_oe(f_oe)
   );

`ifdef BUS_A8_READBACK_EN
   localparam logic RB_EN = 1'b1;
`else
   localparam logic RB_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] addr;
      logic        rw_n;
      logic [7:0]  data;
      logic        ext, mpd, hit;
      logic [3:0]  idx;
      logic [7:0]  ofs;
      int          wr;
      logic        oe;
      logic [7:0]  dout;
   } vec_t;

   vec_t vecs[$];

   logic        s_e_ext, s_e_mpd, s_e_hit, s_ext, s_mpd, s_hit, s_oe_early, s_oe;
   logic [3:0]  s_idx, s_reg_ap, s_reg_ofs;
   logic [7:0]  s_ofs, s_dout, s_reg_data;
   int          s_wr_cnt;
   logic        sf_ext;

   task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %0h expected %0h", name, id, act, exp);
      end
   endtask

   task automatic add(input logic [15:0] addr, input logic rw_n, input logic [7:0] data,
                      input logic ext, input logic mpd, input logic hit, input logic [3:0] idx,
                      input logic [7:0] ofs, input int wr, input logic oe, input logic [7:0] dout);
      vec_t v;
      v.addr = addr; v.rw_n = rw_n; v.data = data; v.ext = ext; v.mpd = mpd; v.hit = hit;
      v.idx = idx; v.ofs = ofs; v.wr = wr; v.oe = oe; v.dout = dout;
      vecs.push_back(v);
   endtask

   // One A8 cycle of 100 clocks on the main instance; phi2 falls at its start
   task automatic bus_cycle(input logic [15:0] addr, input logic rw_n, input logic [7:0] data, input int rst_at);
      @(negedge clk);
      a8_addr = addr; a8_rw_n = rw_n; a8_data = data; a8_clk = 1'b0;
      s_wr_cnt = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (reg_wr) begin
            s_wr_cnt++;
            s_reg_ap = reg_ap; s_reg_ofs = reg_ofs; s_reg_data = reg_data;
         end
         if (k == 6) begin
            s_e_ext = a8_extsel_n; s_e_mpd = a8_mpd_n; s_e_hit = ap_hit;
         end
         if (k == 40) begin
            s_ext = a8_extsel_n; s_mpd = a8_mpd_n; s_hit = ap_hit;
            s_idx = ap_idx; s_ofs = ap_page_ofs; s_oe_early = a8_data_oe;
         end
         if (k == 50) a8_clk = 1'b1;
         if (k == 76) begin
            s_oe = a8_data_oe; s_dout = a8_data_out;
         end
         if (rst_at != 0 && k == rst_at) rst = 1'b1;
         if (rst_at != 0 && k == rst_at + 3) rst = 1'b0;
      end
   endtask

   // Ten-clock A8 cycle on the short-tick instance
   task automatic fast_cycle(input logic [15:0] addr, input logic rw_n, input logic [7:0] data);
      @(negedge clk);
      f_addr = addr; f_rw_n = rw_n; f_data = data; f_clk = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 5) f_clk = 1'b1;
         if (k == 8) sf_ext = f_extsel_n;
      end
   endtask

   initial begin
      //   addr     rw  data   ext mpd hit idx ofs   wr oe dout
      add(16'hD604, 0, 8'h40, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(16'hD605, 0, 8'h04, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(16'h4000, 1, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00);
      add(16'h43FF, 1, 8'h00, 0, 1, 1, 0, 8'h03, 0, 0, 8'h00);
      add(16'h4400, 1, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00);
      add(16'hD605, 0, 8'h10, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(16'hD614, 0, 8'h48, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(16'hD615, 0, 8'h04, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(16'h4900, 1, 8'h00, 0, 1, 1, 0, 8'h09, 0, 0, 8'h00);
      add(16'h4B00, 1, 8'h00, 0, 1, 1, 0, 8'h0B, 0, 0, 8'h00);
      add(16'h4C00, 1, 8'h00, 0, 1, 1, 0, 8'h0C, 0, 0, 8'h00);
      add(16'hD615, 1, 8'h00, 1, 1, 0, 0, 8'h00, 0, 1, 8'h04);
      add(16'hD650, 0, 8'h55, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00);
      add(16'hD650, 1, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00);
      add(16'hD624, 0, 8'hFE, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(16'hD625, 0, 8'h08, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(16'hFE00, 1, 8'h00, 0, 1, 1, 2, 8'h00, 0, 0, 8'h00);
      add(16'hFF10, 1, 8'h00, 0, 1, 1, 2, 8'h01, 0, 0, 8'h00);
      add(16'h0000, 1, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00);
      add(16'h0500, 1, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00);
      add(16'hD634, 0, 8'hD8, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(16'hD635, 0, 8'h01, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(16'hD812, 1, 8'h00, 0, 0, 1, 3, 8'h00, 0, 0, 8'h00);
      add(16'hD700, 1, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00);
      add(16'h4100, 1, 8'h00, 0, 1, 1, 0, 8'h01, 0, 0, 8'h00);

      // Outputs while reset is held
      repeat (4) @(negedge clk);
      chk("rst_extsel_n", 0, a8_extsel_n, 1);
      chk("rst_mpd_n",    0, a8_mpd_n,    1);
      chk("rst_ap_hit",   0, ap_hit,      0);
      chk("rst_ap_idx",   0, ap_idx,      0);
      chk("rst_page_ofs", 0, ap_page_ofs, 0);
      chk("rst_reg_wr",   0, reg_wr,      0);
      chk("rst_data_oe",  0, a8_data_oe,  0);
      chk("rst_data_out", 0, a8_data_out, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      foreach (vecs[i]) begin
         bus_cycle(vecs[i].addr, vecs[i].rw_n, vecs[i].data, 0);
         chk("fall_extsel_n", i, s_e_ext, 1);
         chk("fall_mpd_n",    i, s_e_mpd, 1);
         chk("fall_ap_hit",   i, s_e_hit, 0);
         chk("extsel_n",      i, s_ext, vecs[i].ext);
         chk("mpd_n",         i, s_mpd, vecs[i].mpd);
         chk("ap_hit",        i, s_hit, vecs[i].hit);
         if (vecs[i].hit) begin
            chk("ap_idx",      i, s_idx, vecs[i].idx);
            chk("ap_page_ofs", i, s_ofs, vecs[i].ofs);
         end
         chk("reg_wr_count", i, s_wr_cnt, vecs[i].wr);
         if (vecs[i].wr == 1) begin
            chk("reg_ap",   i, s_reg_ap,   vecs[i].addr[7:4]);
            chk("reg_ofs",  i, s_reg_ofs,  vecs[i].addr[3:0]);
            chk("reg_data", i, s_reg_data, vecs[i].data);
         end
         chk("oe_before_read_tick", i, s_oe_early, 0);
         chk("data_oe", i, s_oe, vecs[i].oe & RB_EN);
         if (vecs[i].oe & RB_EN) chk("data_out", i, s_dout, vecs[i].dout);
         if (!RB_EN)             chk("data_out_idle", i, s_dout, 0);
      end

      // A8 /RST clears bus outputs but keeps registers and map
      a8_rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("a8rst_extsel_n", 0, a8_extsel_n, 1);
      chk("a8rst_ap_hit",   0, ap_hit,      0);
      a8_rst_n = 1'b1;
      repeat (3) @(negedge clk);
      bus_cycle(16'h4100, 1'b1, 8'h00, 0);
      chk("a8rst_map_kept", 0, s_ext, 0);
      chk("a8rst_idx_kept", 0, s_idx, 0);
      chk("a8rst_ofs_kept", 0, s_ofs, 8'h01);

      // Rebuild restart: second start write lands mid-sweep
      fast_cycle(16'hD605, 1'b0, 8'h01);
      repeat (30) @(negedge clk);
      fast_cycle(16'h0000, 1'b1, 8'h00);
      chk("restart_initial_map", 0, sf_ext, 0);
      fast_cycle(16'hD604, 1'b0, 8'h10);
      fast_cycle(16'hD604, 1'b0, 8'h20);
      fast_cycle(16'h0000, 1'b1, 8'h00);
      chk("restart_old_map_held", 1, sf_ext, 0);
      fast_cycle(16'h1000, 1'b1, 8'h00);
      chk("restart_no_partial", 2, sf_ext, 1);
      fast_cycle(16'h2000, 1'b1, 8'h00);
      chk("restart_final_map", 3, sf_ext, 0);
      fast_cycle(16'h0000, 1'b1, 8'h00);
      chk("restart_old_gone", 4, sf_ext, 1);
      fast_cycle(16'h1000, 1'b1, 8'h00);
      chk("restart_mid_gone", 5, sf_ext, 1);

      // Reset during a sweep abandons the rebuild
      bus_cycle(16'hD604, 1'b0, 8'h60, 90);
      repeat (30) @(negedge clk);
      chk("midsweep_extsel_n", 0, a8_extsel_n, 1);
      bus_cycle(16'h6000, 1'b1, 8'h00, 0);
      chk("midsweep_new_page", 0, s_ext, 1);
      bus_cycle(16'h4100, 1'b1, 8'h00, 0);
      chk("midsweep_old_page", 0, s_ext, 1);
      chk("midsweep_hit",      0, s_hit, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_a8_apmap.md
BUS_A8_APMAP -- requirements
Module: bus_a8_apmap

Interface
REQ-001 Parameter TICK_BITS, default 7, width of intra-cycle tick counter.
REQ-002 Parameter TICK_ADDRESS_VALID, default 33, tick at which address is sampled.
REQ-003 Parameter TICK_WRITE_VALID, default 82, tick at which write data is sampled.
REQ-004 Parameter TICK_READ_VALID, default 70, tick at which readback data is driven.
REQ-005 Parameter NUM_AP, default 4 (1..16), number of memory apertures.
REQ-006 Parameter PAGE_MEM_AP, default 8'hD6, host page holding aperture registers.
REQ-007 clk200  in  1  sole FPGA clock, 200 MHz; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 a8_clk, a8_rw_n, a8_rst_n  in  1 each  A8 phi2, read/write, /RST.
REQ-010 a8_addr  in  16  A8 address bus; a8_data  in  8  A8 data bus.
REQ-011 a8_extsel_n  out  1  external select, low = page sourced by FPGA.
REQ-012 a8_mpd_n  out  1  Math-Pak disable, low when a mapped page lies in $D8-$DF.
REQ-013 ap_hit  out  1  current cycle's address falls in an enabled aperture.
REQ-014 ap_idx  out  4  index of hit aperture; ap_page_ofs  out  8  page offset from aperture start.
REQ-015 reg_wr  out  1  one-clock strobe per aperture register write; reg_ap out 4, reg_ofs out 4, reg_data out 8.
REQ-016 a8_data_out  out  8, a8_data_oe  out  1  readback drive (see Configuration).

Function
REQ-017 a8_clk SHALL pass a 3-flop synchroniser; falling edge = synchronised 2'b10.
REQ-018 Tick counter SHALL clear on falling edge, else increment, saturating at all-ones (no wrap).
REQ-019 At tick TICK_ADDRESS_VALID: sample a8_addr; drive a8_extsel_n = ~live_map[addr_hi]; set ap_hit/ap_idx/ap_page_ofs; a8_mpd_n low iff hit and addr_hi in $D8-$DF.
REQ-020 On falling edge a8_extsel_n, a8_mpd_n SHALL return high and ap_hit low; falling edge and address tick in same clock: falling edge wins.
REQ-021 Aperture i occupies $D600+16*i..+15; bytes 0-3 SDRAM base (LE), 4 start page, 5 page count, 6 stride, 7-8 X, 9-A Y, B-C width, D-E height, F reserved (stores, no effect).
REQ-022 At TICK_WRITE_VALID with a8_rw_n=0, addr_hi=PAGE_MEM_AP, addr_lo[7:4]<NUM_AP: store a8_data in register file, pulse reg_wr one clock; writes to absent apertures ignored, no strobe.
REQ-023 Aperture enabled iff count!=0; covers pages start..min(start+count-1, $FF) (clipped, no wrap to $00).
REQ-024 Overlap: lowest-index aperture SHALL win for ap_idx/ap_page_ofs.
REQ-025 Map rebuild FSM: IDLE -> SWEEP (16 clocks, chunk k computes shadow_map[16k+15:16k]) -> COMMIT (1 clock, live_map <= shadow_map) -> IDLE.
REQ-026 Rebuild SHALL start on write to byte 4 or 5 of any aperture; write during SWEEP sets pending, FSM restarts SWEEP after COMMIT.
REQ-027 live_map SHALL change only in COMMIT; address lookups never see a partial map.
REQ-028 a8_rst_n low SHALL reset synchroniser, ticks and bus outputs only; registers and map kept.

Reset
REQ-029 rst SHALL clear all aperture registers, live_map, shadow_map, pending, FSM to IDLE, ticks 0.
REQ-030 Under rst: a8_extsel_n=1, a8_mpd_n=1, ap_hit=0, ap_idx=0, ap_page_ofs=0, reg_wr=0, a8_data_oe=0, a8_data_out=0.
REQ-031 rst mid-SWEEP SHALL abandon rebuild; no COMMIT follows.

Configuration
REQ-032 Macro BUS_A8_READBACK_EN defined: read of implemented aperture register drives a8_data_out and a8_data_oe=1 from TICK_READ_VALID until next falling edge.
REQ-033 Macro undefined: a8_data_oe constant 0, a8_data_out constant 0, no readback mux synthesised.

Structure
REQ-034 Package bus_a8_pkg SHALL hold aperture byte-offset constants, register-file typedef, FSM state enum, PAGE_MEM_AP default.
REQ-035 Sub-module bus_a8_aperture SHALL hold one aperture's 16 bytes and emit enable, start, end page; instantiated NUM_AP times.

Verification
REQ-036 Write $D604=$40, $D605=$04 -> after 18 clocks reads at $4000-$43FF give extsel_n=0, ap_idx=0; $4400 gives extsel_n=1.
REQ-037 Ap0 $40/$10, ap1 $48/$04; access $4900 -> ap_idx=0, ap_page_ofs=$09.
REQ-038 Start $FE, count $08 -> $FE,$FF mapped, $00-$05 not mapped.
REQ-039 Start $D8, count 1, access $D8xx -> a8_mpd_n=0 and a8_extsel_n=0 at tick 33, both high after falling edge.
REQ-040 Two start-page writes 5 clocks apart -> second restarts SWEEP; live_map reflects only final values, one glitch-free transition.
REQ-041 With BUS_A8_READBACK_EN, read $D615 (NUM_AP=4) -> a8_data_oe=1 from tick 70, data = ap1 count; read $D650 -> oe stays 0.
